// File: rtl/frame_arbiter_pkg.sv
// rtl/frame_arbiter_pkg.sv - shared widths, FSM encoding and helpers for frame_arbiter
package frame_arbiter_pkg;

    localparam int COORD_W = 8;
    localparam int LABEL_W = 4;
    localparam int NSRC    = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    // One-hot ready vector for the granted source.
    function automatic logic [NSRC-1:0] src_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/frame_arbiter_if.sv
// rtl/frame_arbiter_if.sv - point stream from one LiDAR source into the arbiter
interface frame_arbiter_if;
    import frame_arbiter_pkg::*;

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic               valid;
    logic               last;
    logic               ready;

    modport master (
        output x,
        output y,
        output z,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  x,
        input  y,
        input  z,
        input  valid,
        input  last,
        output ready
    );

endinterface

// File: rtl/frame_arbiter_rr_arb2.sv
// rtl/frame_arbiter_rr_arb2.sv - combinational 2-way round-robin grant
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       any_o
);

    always_comb begin
        any_o = |req_i;
        case (req_i)
            2'b11:   grant_o = ~last_grant_i;
            2'b10:   grant_o = 1'b1;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/frame_arbiter.sv
// rtl/frame_arbiter.sv - frame-granular round-robin share of octree_stream between two sources
module frame_arbiter
    import frame_arbiter_pkg::*;
#(
    parameter int MAX_PTS  = 1024,
    parameter int DONE_TMO = 4096
) (
    input  logic               clk,
    input  logic               rst,
    frame_arbiter_if.slave     s0,
    frame_arbiter_if.slave     s1,
    output logic [COORD_W-1:0] oct_x_o,
    output logic [COORD_W-1:0] oct_y_o,
    output logic [COORD_W-1:0] oct_z_o,
    output logic               oct_valid_o,
    output logic               oct_last_o,
    input  logic [LABEL_W-1:0] oct_label_i,
    input  logic               oct_out_valid_i,
    input  logic               oct_done_i,
    output logic [LABEL_W-1:0] label_o,
    output logic               label_src_o,
    output logic               label_valid_o,
    output logic               frame_done_o,
    output logic               frame_src_o,
    output logic               err_trunc_o,
    output logic               err_tmo_o
);

    localparam int PCW = $clog2(MAX_PTS + 1);
    localparam int TCW = $clog2(DONE_TMO + 1);

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [PCW-1:0]     pts_cnt_q, pts_cnt_d;
    logic [TCW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [NSRC-1:0]    ready_q, ready_d;

    logic [COORD_W-1:0] oct_x_q, oct_x_d;
    logic [COORD_W-1:0] oct_y_q, oct_y_d;
    logic [COORD_W-1:0] oct_z_q, oct_z_d;
    logic               oct_valid_q, oct_valid_d;
    logic               oct_last_q, oct_last_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic               label_src_q, label_src_d;
    logic               label_valid_q, label_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_src_q, frame_src_d;
    logic               err_trunc_q, err_trunc_d;
    logic               err_tmo_q, err_tmo_d;

    logic               arb_grant;
    logic               arb_any;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [COORD_W-1:0] cur_z;
    logic               cur_valid;
    logic               cur_last;
    logic               accept;
    logic               at_max;
    logic               tmo_hit;

    rr_arb2 u_rr_arb2 (
        .req_i        ({s1.valid, s0.valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_o        (arb_any)
    );

    always_comb begin
        cur_x     = grant_q ? s1.x     : s0.x;
        cur_y     = grant_q ? s1.y     : s0.y;
        cur_z     = grant_q ? s1.z     : s0.z;
        cur_valid = grant_q ? s1.valid : s0.valid;
        cur_last  = grant_q ? s1.last  : s0.last;
    end

    // ready_q is only ever set for the granted source, so it qualifies the accept directly.
    assign accept  = cur_valid & ready_q[grant_q];
    assign at_max  = (pts_cnt_q == PCW'(MAX_PTS - 1));
    assign tmo_hit = (tmo_cnt_q == TCW'(DONE_TMO - 1));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        pts_cnt_d     = pts_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        oct_x_d       = oct_x_q;
        oct_y_d       = oct_y_q;
        oct_z_d       = oct_z_q;
        oct_valid_d   = 1'b0;
        oct_last_d    = 1'b0;
        label_d       = label_q;
        label_src_d   = label_src_q;
        label_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_src_d   = frame_src_q;
        err_trunc_d   = 1'b0;
        err_tmo_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pts_cnt_d = '0;
                if (arb_any) begin
                    grant_d = arb_grant;
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (accept) begin
                    pts_cnt_d   = pts_cnt_q + PCW'(1);
                    oct_valid_d = 1'b1;
                    oct_x_d     = cur_x;
                    oct_y_d     = cur_y;
                    oct_z_d     = cur_z;
                    if (cur_last) begin
                        oct_last_d = 1'b1;
                        tmo_cnt_d  = '0;
                        state_d    = ST_WAIT_DONE;
                    end else if (at_max) begin
                        // Engine sees a clean frame end; the rest of the source frame is swallowed.
                        oct_last_d  = 1'b1;
                        err_trunc_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (accept && cur_last) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                tmo_cnt_d = tmo_cnt_q + TCW'(1);
                if (oct_done_i) begin
                    frame_done_d = 1'b1;
                    frame_src_d  = grant_q;
                    last_grant_d = grant_q;
                    pts_cnt_d    = '0;
                    state_d      = ST_IDLE;
                end else if (tmo_hit) begin
                    err_tmo_d    = 1'b1;
                    last_grant_d = grant_q;
                    pts_cnt_d    = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (oct_out_valid_i && (state_q != ST_IDLE)) begin
            label_d       = oct_label_i;
            label_src_d   = grant_q;
            label_valid_d = 1'b1;
        end

        // Ready follows the upcoming state only, never the current valid.
        if ((state_d == ST_STREAM) || (state_d == ST_DRAIN)) begin
            ready_d = src_onehot(grant_d);
        end else begin
            ready_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            pts_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            ready_q       <= '0;
            oct_x_q       <= '0;
            oct_y_q       <= '0;
            oct_z_q       <= '0;
            oct_valid_q   <= 1'b0;
            oct_last_q    <= 1'b0;
            label_q       <= '0;
            label_src_q   <= 1'b0;
            label_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_src_q   <= 1'b0;
            err_trunc_q   <= 1'b0;
            err_tmo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            pts_cnt_q     <= pts_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            ready_q       <= ready_d;
            oct_x_q       <= oct_x_d;
            oct_y_q       <= oct_y_d;
            oct_z_q       <= oct_z_d;
            oct_valid_q   <= oct_valid_d;
            oct_last_q    <= oct_last_d;
            label_q       <= label_d;
            label_src_q   <= label_src_d;
            label_valid_q <= label_valid_d;
            frame_done_q  <= frame_done_d;
            frame_src_q   <= frame_src_d;
            err_trunc_q   <= err_trunc_d;
            err_tmo_q     <= err_tmo_d;
        end
    end

    assign s0.ready      = ready_q[0];
    assign s1.ready      = ready_q[1];
    assign oct_x_o       = oct_x_q;
    assign oct_y_o       = oct_y_q;
    assign oct_z_o       = oct_z_q;
    assign oct_valid_o   = oct_valid_q;
    assign oct_last_o    = oct_last_q;
    assign label_o       = label_q;
    assign label_src_o   = label_src_q;
    assign label_valid_o = label_valid_q;
    assign frame_done_o  = frame_done_q;
    assign frame_src_o   = frame_src_q;
    assign err_trunc_o   = err_trunc_q;
    assign err_tmo_o     = err_tmo_q;

endmodule

// File: tb/tb_frame_arbiter.sv
// tb/tb_frame_arbiter.sv - self-checking bench for frame_arbiter against a frame-level model
module tb_frame_arbiter;
    import frame_arbiter_pkg::*;

    localparam int MAXP = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_arbiter_if s0_if ();
    frame_arbiter_if s1_if ();

    logic [7:0] oct_x, oct_y, oct_z;
    logic       oct_valid, oct_last;
    logic [3:0] oct_label     = 4'h0;
    logic       oct_out_valid = 1'b0;
    logic       oct_done      = 1'b0;
    logic [3:0] label;
    logic       label_src, label_valid, frame_done, frame_src, err_trunc, err_tmo;

    frame_arbiter #(.MAX_PTS(MAXP), .DONE_TMO(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .s0              (s0_if),
        .s1              (s1_if),
        .oct_x_o         (oct_x),
        .oct_y_o         (oct_y),
        .oct_z_o         (oct_z),
        .oct_valid_o     (oct_valid),
        .oct_last_o      (oct_last),
        .oct_label_i     (oct_label),
        .oct_out_valid_i (oct_out_valid),
        .oct_done_i      (oct_done),
        .label_o         (label),
        .label_src_o     (label_src),
        .label_valid_o   (label_valid),
        .frame_done_o    (frame_done),
        .frame_src_o     (frame_src),
        .err_trunc_o     (err_trunc),
        .err_tmo_o       (err_tmo)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {int cyc; logic src; logic [23:0] d; logic last;} beat_t;
    typedef struct packed {int cyc; logic src; logic [3:0] lab;} ev_t;
    beat_t acc_q[$];
    beat_t oct_q[$];
    ev_t   done_q[$];
    ev_t   lab_q[$];
    int    trunc_q[$];
    int    tmo_q[$];

    always @(negedge clk) begin
        if (s0_if.valid && s0_if.ready) acc_q.push_back('{cyc, 1'b0, {s0_if.x, s0_if.y, s0_if.z}, s0_if.last});
        if (s1_if.valid && s1_if.ready) acc_q.push_back('{cyc, 1'b1, {s1_if.x, s1_if.y, s1_if.z}, s1_if.last});
        if (oct_valid)   oct_q.push_back('{cyc, 1'b0, {oct_x, oct_y, oct_z}, oct_last});
        if (frame_done)  done_q.push_back('{cyc, frame_src, 4'h0});
        if (label_valid) lab_q.push_back('{cyc, label_src, label});
        if (err_trunc)   trunc_q.push_back(cyc);
        if (err_tmo)     tmo_q.push_back(cyc);
    end

    logic [23:0] mem [2][16];
    int          flen [2];
    bit          fin [2];
    logic        mlast = 1'b1;

    int          m_nf;
    int          m_src [2];
    int          m_len [2];
    int          m_done_cyc [2];
    bit          m_tmo [2];
    bit          m_lab;
    logic [3:0]  m_lab_v;
    int          m_lab_src;
    int          m_lab_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input logic [23:0] d, input logic l);
        if (s == 0) begin
            s0_if.valid = v; {s0_if.x, s0_if.y, s0_if.z} = d; s0_if.last = l;
        end else begin
            s1_if.valid = v; {s1_if.x, s1_if.y, s1_if.z} = d; s1_if.last = l;
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? s0_if.ready : s1_if.ready;
    endfunction

    task automatic new_frame(input int s, input int len);
        flen[s] = len;
        for (int i = 0; i < len; i++) mem[s][i] = 24'($urandom);
    endtask

    task automatic drive(input int s, input int gmax);
        for (int i = 0; i < flen[s]; i++) begin
            int w = 0;
            if (i > 0) repeat ($urandom_range(0, gmax)) step();
            set_src(s, 1'b1, mem[s][i], i == flen[s] - 1);
            do begin
                @(negedge clk);
                w++;
            end while (!rdy(s) && w < 200);
            chk("drv_accept_wait", 32'(w < 200), 1);
            step();
            set_src(s, 1'b0, 24'h0, 1'b0);
        end
        fin[s] = 1'b1;
    endtask

    task automatic wait_fin(input int s);
        int w = 0;
        while (!fin[s] && w < 500) begin
            step();
            w++;
        end
        chk("frame_end_wait", 32'(fin[s]), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_oct_valid"}, oct_valid, 0);
        chk({tag, "_oct_last"}, oct_last, 0);
        chk({tag, "_oct_xyz"}, {oct_x, oct_y, oct_z}, 0);
        chk({tag, "_label"}, label, 0);
        chk({tag, "_label_src"}, label_src, 0);
        chk({tag, "_label_valid"}, label_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_src"}, frame_src, 0);
        chk({tag, "_err_trunc"}, err_trunc, 0);
        chk({tag, "_err_tmo"}, err_tmo, 0);
        chk({tag, "_s0_ready"}, s0_if.ready, 0);
        chk({tag, "_s1_ready"}, s1_if.ready, 0);
    endtask

    task automatic clear_q();
        acc_q.delete(); oct_q.delete(); done_q.delete(); lab_q.delete();
        trunc_q.delete(); tmo_q.delete();
    endtask

    // Expected traffic is derived per frame: first min(len,MAXP) points forwarded, one cycle after accept.
    task automatic check_run();
        int ai = 0, oi = 0, ntr = 0, nd = 0, nt = 0;
        int s_acc = 0, s_oct = 0, e_tr = 0, e_done = 0, e_tmo = 0;
        for (int f = 0; f < m_nf; f++) begin
            s_acc += m_len[f];
            s_oct += (m_len[f] > MAXP) ? MAXP : m_len[f];
            if (m_len[f] > MAXP) e_tr++;
            if (m_tmo[f]) e_tmo++; else e_done++;
        end
        chk("acc_count", acc_q.size(), s_acc);
        chk("oct_count", oct_q.size(), s_oct);
        chk("trunc_count", trunc_q.size(), e_tr);
        chk("done_count", done_q.size(), e_done);
        chk("tmo_count", tmo_q.size(), e_tmo);
        for (int f = 0; f < m_nf; f++) begin
            int n = (m_len[f] > MAXP) ? MAXP : m_len[f];
            int last_acc = 0;
            for (int i = 0; i < m_len[f]; i++) begin
                if (ai < acc_q.size()) begin
                    beat_t a;
                    a = acc_q[ai];
                    chk("acc_src", a.src, m_src[f]);
                    chk("acc_data", a.d, mem[m_src[f]][i]);
                    chk("acc_last", a.last, i == m_len[f] - 1);
                    if (i < n && oi < oct_q.size()) begin
                        chk("oct_data", oct_q[oi].d, mem[m_src[f]][i]);
                        chk("oct_last", oct_q[oi].last, i == n - 1);
                        chk("oct_latency", oct_q[oi].cyc, a.cyc + 1);
                        oi++;
                    end
                    if (m_len[f] > MAXP && i == MAXP - 1 && ntr < trunc_q.size()) begin
                        chk("trunc_cycle", trunc_q[ntr], a.cyc + 1);
                        ntr++;
                    end
                    last_acc = a.cyc;
                end
                ai++;
            end
            if (m_tmo[f]) begin
                if (nt < tmo_q.size()) chk("tmo_cycle", tmo_q[nt], last_acc + 1 + TMO);
                nt++;
            end else begin
                if (nd < done_q.size()) begin
                    chk("done_cycle", done_q[nd].cyc, m_done_cyc[f] + 1);
                    chk("done_src", done_q[nd].src, m_src[f]);
                end
                nd++;
            end
        end
        chk("label_count", lab_q.size(), m_lab ? 1 : 0);
        if (m_lab && lab_q.size() > 0) begin
            chk("label_value", lab_q[0].lab, m_lab_v);
            chk("label_src", lab_q[0].src, m_lab_src);
            chk("label_cycle", lab_q[0].cyc, m_lab_cyc + 1);
        end
        clear_q();
    endtask

    task automatic run_frames(input logic [1:0] mask, input int l0, input int l1, input int gmax,
                              input int dly, input bit tmo, input bit lab, input logic [3:0] labv);
        if (mask[0]) new_frame(0, l0);
        if (mask[1]) new_frame(1, l1);
        if (mask == 2'b11) begin
            m_nf = 2;
            m_src[0] = mlast ? 0 : 1;
            m_src[1] = 1 - m_src[0];
        end else begin
            m_nf = 1;
            m_src[0] = mask[1] ? 1 : 0;
        end
        for (int f = 0; f < m_nf; f++) begin
            m_len[f] = flen[m_src[f]];
            m_tmo[f] = tmo;
        end
        m_lab  = lab;
        fin[0] = ~mask[0];
        fin[1] = ~mask[1];
        if (mask[0]) fork drive(0, gmax); join_none
        if (mask[1]) fork drive(1, gmax); join_none
        step();
        step();
        if (lab) begin
            oct_label     = labv;
            m_lab_v       = labv;
            m_lab_src     = m_src[0];
            m_lab_cyc     = cyc;
            oct_out_valid = 1'b1;
            step();
            oct_out_valid = 1'b0;
        end
        for (int f = 0; f < m_nf; f++) begin
            wait_fin(m_src[f]);
            if (tmo) begin
                repeat (TMO + 3) step();
            end else begin
                repeat (dly) step();
                m_done_cyc[f] = cyc;
                oct_done = 1'b1;
                step();
                oct_done = 1'b0;
            end
            mlast = m_src[f][0];
        end
        repeat (3) step();
        check_run();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int nl;
        set_src(0, 1'b0, 24'h0, 1'b0);
        set_src(1, 1'b0, 24'h0, 1'b0);
        rst = 1'b1;
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Tie out of reset goes to s0, then s1; the following tie goes back to s0.
        run_frames(2'b11, 3, 2, 0, 1, 1'b0, 1'b0, 4'h0);
        run_frames(2'b11, 2, 2, 0, 0, 1'b0, 1'b0, 4'h0);
        run_frames(2'b01, 3, 0, 0, 0, 1'b0, 1'b0, 4'h0);
        run_frames(2'b10, 0, 6, 0, 1, 1'b0, 1'b0, 4'h0);
        run_frames(2'b01, 2, 0, 0, 0, 1'b1, 1'b0, 4'h0);
        run_frames(2'b10, 0, 3, 1, 0, 1'b0, 1'b1, 4'hA);
        run_frames(2'b01, 1, 0, 0, 0, 1'b0, 1'b0, 4'h0);

        // Labels and done strobes seen in IDLE must be dropped.
        oct_label = 4'h5;
        oct_out_valid = 1'b1;
        oct_done = 1'b1;
        step();
        oct_out_valid = 1'b0;
        oct_done = 1'b0;
        repeat (3) step();
        chk("idle_label_drop", lab_q.size(), 0);
        chk("idle_done_drop", done_q.size(), 0);
        clear_q();

        // Reset in the middle of a frame.
        set_src(0, 1'b1, 24'h123456, 1'b0);
        w = 0;
        while (acc_q.size() < 2 && w < 50) begin
            step();
            w++;
        end
        chk("pre_reset_accepts", 32'(acc_q.size() >= 2), 1);
        rst = 1'b1;
        step();
        chk_zero("midreset");
        set_src(0, 1'b0, 24'h0, 1'b0);
        step();
        rst = 1'b0;
        step();
        oct_done = 1'b1;
        step();
        oct_done = 1'b0;
        repeat (4) step();
        chk("spurious_done", done_q.size(), 0);
        nl = 0;
        foreach (oct_q[i]) if (oct_q[i].last) nl++;
        chk("reset_no_last", nl, 0);
        clear_q();
        mlast = 1'b1;

        for (int it = 0; it < 25; it++) begin
            run_frames(2'($urandom_range(1, 3)), $urandom_range(1, 7), $urandom_range(1, 7),
                       $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                       1'($urandom_range(0, 1)), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
